// File: rtl/ddr_cmd_arbiter_if.sv
// Requester-side and DDR-engine-side signal bundle of ddr_cmd_arbiter.
// slave = arbiter view; master = requesters plus the AXI DDR engine.
interface ddr_cmd_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int LEN_W   = 24
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*LEN_W-1:0]  req_len;
    logic [NUM_REQ-1:0]        req_type;
    logic [NUM_REQ-1:0]        ack;
    logic [NUM_REQ-1:0]        done;
    logic [ADDR_W-1:0]         ddr_st_addr_out;
    logic [LEN_W-1:0]          ddr_len;
    logic                      ddr_conf;
    logic                      cmd_type;
    logic                      idle;
    logic                      busy;
    logic [2:0]                owner;
    logic                      timeout_err;

    modport slave (
        input  req, req_addr, req_len, req_type, idle,
        output ack, done, ddr_st_addr_out, ddr_len, ddr_conf, cmd_type,
               busy, owner, timeout_err
    );

    modport master (
        output req, req_addr, req_len, req_type, idle,
        input  ack, done, ddr_st_addr_out, ddr_len, ddr_conf, cmd_type,
               busy, owner, timeout_err
    );
endinterface

// File: rtl/ddr_cmd_arbiter.sv
// Round-robin arbiter sharing one AXI DDR transfer engine between NUM_REQ requesters.
// Optional watchdog on the engine's idle return: define DDR_ARB_TIMEOUT_EN.
module ddr_cmd_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int LEN_W   = 24,
    parameter int DATA_W  = 32,
    parameter int TO_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             init_cmptd,
    ddr_cmd_arbiter_if.slave bus
);
    localparam int BEAT_BYTES = DATA_W / 8;
    localparam int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_SETTLE,
        S_WAIT_IDLE,
        S_FINISH
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               type_q, type_d;

    logic               run;
    logic               grant_vld;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   cand;
    logic [LEN_W-1:0]   sel_len;
    logic               zero_len;
    logic [NUM_REQ-1:0] ack_c;
    logic [NUM_REQ-1:0] done_c;
    logic               conf_c;

`ifdef DDR_ARB_TIMEOUT_EN
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic               timeout_err_q, timeout_err_d;
`endif

    // Calibration not finished is indistinguishable from reset.
    assign run = rst_n & init_cmptd;

    always_comb begin : rr_pick
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!grant_vld && bus.req[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign sel_len  = bus.req_len[int'(grant_idx)*LEN_W +: LEN_W];
    assign zero_len = (sel_len < LEN_W'(BEAT_BYTES));

    always_comb begin : next_state
        // NOTE: every combinational output gets its default before the case so no path infers a latch.
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        len_d   = len_q;
        type_d  = type_q;
        ack_c   = '0;
        done_c  = '0;
        conf_c  = 1'b0;
`ifdef DDR_ARB_TIMEOUT_EN
        to_cnt_d      = to_cnt_q;
        timeout_err_d = timeout_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (grant_vld && bus.idle) begin
                    ack_c[grant_idx] = 1'b1;
                    owner_d = grant_idx;
                    ptr_d   = grant_idx;
                    addr_d  = bus.req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
                    len_d   = sel_len;
                    type_d  = bus.req_type[grant_idx];
                    state_d = zero_len ? S_FINISH : S_ISSUE;
                end
            end
            S_ISSUE: begin
                conf_c  = 1'b1;
                state_d = S_SETTLE;
`ifdef DDR_ARB_TIMEOUT_EN
                to_cnt_d = '0;
`endif
            end
            // The engine's idle still shows its pre-conf value here.
            S_SETTLE: state_d = S_WAIT_IDLE;
            S_WAIT_IDLE: begin
                if (bus.idle) begin
                    state_d = S_FINISH;
                end
`ifdef DDR_ARB_TIMEOUT_EN
                else if (&to_cnt_q) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_FINISH;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
`endif
            end
            S_FINISH: begin
                done_c[owner_q] = 1'b1;
                state_d         = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
        if (!run) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            ptr_q   <= IDX_W'(NUM_REQ - 1);
            addr_q  <= '0;
            len_q   <= '0;
            type_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            type_q  <= type_d;
        end
    end

`ifdef DDR_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!run) begin
            to_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            to_cnt_q      <= to_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.timeout_err = timeout_err_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

    // Strobes are masked during reset so an abort never leaks a pulse.
    assign bus.ack             = run ? ack_c  : '0;
    assign bus.done            = run ? done_c : '0;
    assign bus.ddr_conf        = run & conf_c;
    assign bus.ddr_st_addr_out = addr_q;
    assign bus.ddr_len         = len_q;
    assign bus.cmd_type        = type_q;
    assign bus.busy            = (state_q != S_IDLE);
    assign bus.owner           = 3'(owner_q);
endmodule

// File: tb/tb_ddr_cmd_arbiter.sv
// Self-checking bench for ddr_cmd_arbiter: directed scenarios plus randomized
// requesters and engine, compared every cycle against a timestamp-based model.
module tb_ddr_cmd_arbiter;
    localparam int NUM_REQ    = 4;
    localparam int ADDR_W     = 32;
    localparam int LEN_W      = 24;
    localparam int DATA_W     = 32;
    localparam int BEAT_BYTES = DATA_W / 8;

    logic clk = 1'b0;
    logic rst_n;
    logic init_cmptd;

    ddr_cmd_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

    ddr_cmd_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W), .TO_W(16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_cmptd(init_cmptd),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Round-robin rule: first set bit above the last grantee, wrapping.
    function automatic int pick(input logic [NUM_REQ-1:0] r, input int last);
        for (int k = 1; k <= NUM_REQ; k++)
            if (r[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        return -1;
    endfunction

    function automatic int idx_of(input logic [NUM_REQ-1:0] v);
        for (int i = 0; i < NUM_REQ; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    // Model: a grant at cycle g busies the arbiter for g+1..d; conf at g+1,
    // done at d = g+1 (zero beats) or one cycle after idle is seen from g+3 on.
    int                 m_cyc   = 0;
    int                 m_last  = NUM_REQ - 1;
    bit                 m_act   = 1'b0;
    bit                 m_zero  = 1'b0;
    int                 m_gcyc  = 0;
    int                 m_gid   = 0;
    int                 m_dcyc  = -1;
    int                 m_win   = -1;
    int                 m_owner = 0;
    logic [ADDR_W-1:0]  m_addr  = '0;
    logic [LEN_W-1:0]   m_len   = '0;
    logic               m_type  = 1'b0;
    bit                 m_run;
    logic [NUM_REQ-1:0] e_ack, e_done;
    logic               e_conf, e_busy;

    always @(negedge clk) begin
        m_run  = rst_n && init_cmptd;
        e_ack  = '0;
        e_done = '0;
        e_conf = 1'b0;
        e_busy = m_act;
        m_win  = -1;
        if (m_act) begin
            if (m_run && !m_zero && m_cyc == m_gcyc + 1) e_conf = 1'b1;
            if (m_run && m_cyc == m_dcyc) e_done[m_gid] = 1'b1;
        end else if (m_run && bus.idle && bus.req != '0) begin
            m_win = pick(bus.req, m_last);
            e_ack[m_win] = 1'b1;
        end

        check("ack",         bus.ack,             e_ack);
        check("done",        bus.done,            e_done);
        check("ddr_conf",    bus.ddr_conf,        e_conf);
        check("busy",        bus.busy,            e_busy);
        check("owner",       bus.owner,           m_owner);
        check("addr",        bus.ddr_st_addr_out, m_addr);
        check("len",         bus.ddr_len,         m_len);
        check("cmd_type",    bus.cmd_type,        m_type);
        check("timeout_err", bus.timeout_err,     1'b0);

        if (!m_run) begin
            m_act = 1'b0; m_last = NUM_REQ - 1; m_owner = 0;
            m_addr = '0; m_len = '0; m_type = 1'b0;
        end else if (m_act) begin
            if (m_cyc == m_dcyc) m_act = 1'b0;
            else if (!m_zero && m_dcyc < 0 && m_cyc >= m_gcyc + 3 && bus.idle) m_dcyc = m_cyc + 1;
        end else if (m_win >= 0) begin
            m_act   = 1'b1;
            m_gcyc  = m_cyc;
            m_gid   = m_win;
            m_last  = m_win;
            m_owner = m_win;
            m_addr  = bus.req_addr[m_win*ADDR_W +: ADDR_W];
            m_len   = bus.req_len[m_win*LEN_W +: LEN_W];
            m_type  = bus.req_type[m_win];
            m_zero  = (m_len < LEN_W'(BEAT_BYTES));
            m_dcyc  = m_zero ? m_cyc + 1 : -1;
        end
        m_cyc++;
    end

    // Stimulus side: samples of the previous cycle plus a simple engine.
    logic [NUM_REQ-1:0] s_ack, s_done;
    logic               s_conf, s_busy, s_type;
    logic [ADDR_W-1:0]  s_addr;
    logic [LEN_W-1:0]   s_len;
    logic [2:0]         s_owner;
    bit                 auto_eng = 1'b0;
    bit                 noise    = 1'b0;
    int                 eng_left = 0;
    int                 eng_hold = 3;

    task automatic next_cycle();
        @(negedge clk);
        s_ack = bus.ack;   s_done = bus.done;   s_conf  = bus.ddr_conf; s_busy = bus.busy;
        s_addr = bus.ddr_st_addr_out; s_len = bus.ddr_len; s_type = bus.cmd_type; s_owner = bus.owner;
        @(posedge clk);
        #1;
        if (auto_eng) begin
            if (s_conf) eng_left = eng_hold;
            if (eng_left > 0) begin
                bus.idle = 1'b0;
                eng_left--;
            end else begin
                bus.idle = !(noise && $urandom_range(0, 7) == 0);
            end
        end
    endtask

    task automatic set_slot(input int i, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l, input logic t);
        bus.req_addr[i*ADDR_W +: ADDR_W] = a;
        bus.req_len[i*LEN_W +: LEN_W]    = l;
        bus.req_type[i]                  = t;
    endtask

    function automatic logic [LEN_W-1:0] rand_len();
        case ($urandom_range(0, 5))
            0:       return LEN_W'(0);
            1:       return LEN_W'(BEAT_BYTES - 1);
            2:       return LEN_W'(BEAT_BYTES);
            3:       return LEN_W'(BEAT_BYTES + 1);
            4:       return LEN_W'(256);
            default: return LEN_W'($urandom_range(0, 4096));
        endcase
    endfunction

    task automatic drain(input string name);
        int n = 0;
        bus.req = '0;
        next_cycle();
        while (s_busy && n < 100) begin
            next_cycle();
            n++;
        end
        check(name, s_busy, 1'b0);
    endtask

    int order [5] = '{0, 1, 2, 3, 0};
    int ng, nconf, ndone;

    initial begin
        rst_n = 1'b0; init_cmptd = 1'b1;
        bus.req = '0; bus.req_addr = '0; bus.req_len = '0; bus.req_type = '0; bus.idle = 1'b1;
        repeat (3) next_cycle();

        // Calibration pending with every request raised.
        rst_n = 1'b1; init_cmptd = 1'b0; bus.req = '1;
        for (int i = 0; i < NUM_REQ; i++) set_slot(i, ADDR_W'(32'h40 * i), LEN_W'(64), 1'b1);
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            check("t1_ack", s_ack, 4'b0000);
            check("t1_conf", s_conf, 1'b0);
            check("t1_busy", s_busy, 1'b0);
            check("t1_addr", s_addr, 32'h0);
            check("t1_owner", s_owner, 3'd0);
        end

        // Single read on requester 2 with a slow engine.
        init_cmptd = 1'b1; bus.req = '0;
        set_slot(2, 32'h1000, LEN_W'(256), 1'b0);
        next_cycle();
        bus.req = 4'b0100;
        next_cycle();
        check("t2_ack", s_ack, 4'b0100);
        bus.req = '0;
        next_cycle();
        check("t2_conf", s_conf, 1'b1);
        check("t2_addr", s_addr, 32'h1000);
        check("t2_len", s_len, 24'd256);
        check("t2_type", s_type, 1'b0);
        check("t2_owner", s_owner, 3'd2);
        bus.idle = 1'b0;
        for (int c = 0; c < 20; c++) begin
            next_cycle();
            check("t2_no_early_done", s_done, 4'b0000);
        end
        bus.idle = 1'b1;
        next_cycle();
        check("t2_done_not_same_cycle", s_done, 4'b0000);
        next_cycle();
        check("t2_done", s_done, 4'b0100);
        next_cycle();
        check("t2_back_idle", s_busy, 1'b0);

        // All four requesting continuously from a fresh pointer.
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) set_slot(i, ADDR_W'(32'h100 * i), LEN_W'(64), i[0]);
        auto_eng = 1'b1; eng_hold = 3; bus.req = '1;
        ng = 0; nconf = 0; ndone = 0;
        for (int c = 0; c < 200 && ng < 5; c++) begin
            next_cycle();
            if (s_done != '0) ndone++;
            if (s_conf) begin
                check("t3_conf_after_done", ndone, nconf);
                nconf++;
            end
            if (s_ack != '0) begin
                check("t3_grant_order", idx_of(s_ack), order[ng]);
                ng++;
            end
        end
        check("t3_grant_count", ng, 5);
        drain("t3_drain");

        // Zero-beat request: done right after ack, engine never configured.
        set_slot(1, 32'h2000, LEN_W'(2), 1'b1);
        bus.req = 4'b0010;
        next_cycle();
        check("t4_ack", s_ack, 4'b0010);
        bus.req = '0;
        next_cycle();
        check("t4_done", s_done, 4'b0010);
        check("t4_no_conf", s_conf, 1'b0);
        next_cycle();
        check("t4_no_conf_later", s_conf, 1'b0);
        check("t4_idle", s_busy, 1'b0);

        // Reset while waiting on the engine: silent abort, pointer restored.
        auto_eng = 1'b0; bus.idle = 1'b1;
        set_slot(1, 32'h3000, LEN_W'(128), 1'b0);
        bus.req = 4'b0010;
        next_cycle();
        check("t5_ack", s_ack, 4'b0010);
        bus.req = '0;
        next_cycle();
        bus.idle = 1'b0;
        repeat (4) next_cycle();
        check("t5_waiting", s_busy, 1'b1);
        rst_n = 1'b0;
        next_cycle();
        check("t5_no_done_in_reset", s_done, 4'b0000);
        rst_n = 1'b1;
        next_cycle();
        check("t5_busy_cleared", s_busy, 1'b0);
        check("t5_owner_cleared", s_owner, 3'd0);
        check("t5_no_done_after", s_done, 4'b0000);
        // Pointer back at NUM_REQ-1 makes requester 1 win over 2.
        bus.idle = 1'b1;
        set_slot(2, 32'h4000, LEN_W'(64), 1'b1);
        bus.req = 4'b0110;
        next_cycle();
        check("t5_regrant", s_ack, 4'b0010);
        auto_eng = 1'b1;
        drain("t5_drain");

        // Randomized requesters, engine latency, idle glitches and resets.
        noise = 1'b1;
        for (int c = 0; c < 2500; c++) begin
            eng_hold   = $urandom_range(0, 10);
            rst_n      = ($urandom_range(0, 299) != 0);
            init_cmptd = ($urandom_range(0, 499) != 0);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.req[i] && s_ack[i]) begin
                    bus.req[i] = 1'b0;
                end else if (!bus.req[i] && $urandom_range(0, 3) == 0) begin
                    set_slot(i, ADDR_W'($urandom), rand_len(), 1'($urandom_range(0, 1)));
                    bus.req[i] = 1'b1;
                end else if (bus.req[i] && $urandom_range(0, 39) == 0) begin
                    bus.req[i] = 1'b0;
                end
            end
            next_cycle();
        end
        rst_n = 1'b1; init_cmptd = 1'b1; noise = 1'b0;
        drain("final_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end
endmodule

// File: doc/ddr_cmd_arbiter.md
Name: ddr_cmd_arbiter

Overview:
Round-robin scheduler that shares the single AXI DDR transfer engine (the ddr_st_addr_out/ddr_len/ddr_conf/cmd_type/idle command interface) between NUM_REQ requesters.
- Grants one request at a time, latches its address/length/type, pulses the one-cycle configure strobe, then holds the engine until it reports idle.
- Returns a per-requester done pulse on completion.
- Sits between the layer/feature-map controllers and the DDR AXI engine.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 32, DDR byte address width
LEN_W, 24, transfer length width in bytes
DATA_W, 32, engine AXI data width; BEAT_BYTES = DATA_W/8
TO_W, 16, watchdog counter width (used only with the optional feature)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
init_cmptd  in  1  DDR calibration done; low is treated as reset
req  in  NUM_REQ  per-requester request level; held until ack
req_addr  in  NUM_REQ*ADDR_W  start byte address, requester i at [i*ADDR_W +: ADDR_W]
req_len  in  NUM_REQ*LEN_W  length in bytes, requester i at [i*LEN_W +: LEN_W]
req_type  in  NUM_REQ  1=write (DDR<-in_fifo), 0=read (DDR->ddr_fifo)
ack  out  NUM_REQ  one-cycle pulse: request accepted, inputs may change
done  out  NUM_REQ  one-cycle pulse: transfer finished
ddr_st_addr_out  out  ADDR_W  to engine
ddr_len  out  LEN_W  to engine
ddr_conf  out  1  one-cycle configure strobe to engine
cmd_type  out  1  to engine
idle  in  1  engine idle (all channels idle, no pending B response)
busy  out  1  arbiter not in IDLE
owner  out  3  index of current/last grantee
timeout_err  out  1  sticky watchdog error (0 when feature is off)

Behaviour:
- Reset (rst_n==0 or init_cmptd==0, sampled at clk):
  - State goes to IDLE.
  - ack, done, ddr_conf, busy, cmd_type, ddr_st_addr_out, ddr_len, timeout_err all 0; owner=0; RR pointer=NUM_REQ-1.
  - Reset mid-transfer aborts silently: no done pulse. Requesters must re-request.
- States: IDLE, ISSUE, SETTLE, WAIT_IDLE, FINISH.
- IDLE:
  - When any req bit is set and idle==1, select the first set bit searching from (ptr+1) mod NUM_REQ upward with wrap.
  - Latch that requester's addr/len/type into ddr_st_addr_out/ddr_len/cmd_type.
  - Pulse ack[i], set owner=i and ptr=i.
  - If req_len < BEAT_BYTES (zero beats), go to FINISH without issuing. Otherwise go to ISSUE.
  - If idle==0 in IDLE, no grant is made; requests wait.
- ISSUE: ddr_conf=1 for exactly this cycle; go to SETTLE.
- SETTLE: one cycle; idle is ignored because the engine updates its idle on the clock after conf; go to WAIT_IDLE.
- WAIT_IDLE: hold outputs stable; on idle==1 go to FINISH.
- FINISH: pulse done[owner] for one cycle; go to IDLE. The earliest next grant is the following cycle.
- Latency, in cycles after the granting edge:
  - ddr_conf at +1.
  - Minimum done = engine idle return + 1.
  - Zero-length request: done at +1.
- Fairness: a requester holding req is granted within NUM_REQ transfers.
- ack and done are never asserted in the same cycle for the same requester, except that done for a zero-length request occurs one cycle after its ack.
- req bits deasserted before grant are simply not served. There is no request queueing.
- ddr_len is passed unmodified. Lengths that are not a multiple of BEAT_BYTES are truncated by the engine; the arbiter does not round.
- busy = (state != IDLE).

Optional Feature:
DDR_ARB_TIMEOUT_EN
- Defined:
  - A TO_W-bit counter clears in ISSUE and increments each cycle in WAIT_IDLE.
  - At all-ones: set timeout_err (sticky until reset), pulse done[owner], return to IDLE.
- Undefined: no counter; timeout_err is tied to 0; WAIT_IDLE waits indefinitely.

Test Plan:
- Reset with init_cmptd=0 and req=4'b1111 -> no ack and no ddr_conf for 10 cycles; all outputs 0.
- req[2]=1, addr=0x1000, len=256, type=0, engine idle low for 20 cycles after conf -> ack[2] at T, ddr_conf at T+1 with addr=0x1000, len=256, cmd_type=0; done[2] one cycle after idle returns.
- req=4'b1111 held continuously -> grant order 0,1,2,3,0; each ddr_conf occurs only after the prior done.
- req[1] with len=2 (DATA_W=32) -> ack[1], done[1] one cycle later, ddr_conf never asserted.
- rst_n pulsed low during WAIT_IDLE -> state IDLE, no done pulse, ptr=NUM_REQ-1, so the next grant with req=4'b0001 goes to 0.
- DDR_ARB_TIMEOUT_EN with TO_W=4 and idle held low -> done[owner] 15 cycles into WAIT_IDLE, timeout_err=1 and stays 1.
